// File: rtl/ledseq_pkg.sv
// Shared encodings for the multi-mode LED sequencer.
package ledseq_pkg;

   localparam int SPEED_W = 2;

   typedef enum logic [1:0] {
      MODE_ROTL   = 2'd0,
      MODE_ROTR   = 2'd1,
      MODE_BOUNCE = 2'd2,
      MODE_FLASH  = 2'd3
   } mode_e;

endpackage

// File: rtl/ledseq_prescaler.sv
// Period prescaler: free-running counter cleared at a speed-selected limit.
// o_advance is the same-edge update strobe; o_tick is its registered copy.
module ledseq_prescaler
   import ledseq_pkg::*;
#(
   parameter int NB_COUNT = 32,
   parameter int NB_BASE  = 22
) (
   input  logic               clk,
   input  logic               i_reset,
   input  logic               i_enable,
   input  logic [SPEED_W-1:0] i_speed,
   output logic               o_advance,
   output logic               o_tick
);

   localparam logic [NB_COUNT-1:0] ONE = NB_COUNT'(1);

   logic [NB_COUNT-1:0] count;
   logic [NB_COUNT-1:0] limit;

   // >= rather than == so a speed drop below the current count ticks at once.
   assign limit     = (ONE << (NB_BASE + int'(i_speed))) - ONE;
   assign o_advance = i_enable && (count >= limit);

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk or posedge i_reset) begin
      if (i_reset) begin
         count  <= '0;
         o_tick <= 1'b0;
      end else begin
         o_tick <= o_advance;
         if (o_advance) begin
            count <= '0;
         end else if (i_enable) begin
            count <= count + ONE;
         end
      end
   end

endmodule

// File: rtl/ledseq_multimode.sv
// Multi-mode LED sequencer: rotate-left/right, bounce and flash patterns.
// Bounce mode is built only when LEDSEQ_BOUNCE_EN is defined; otherwise it rotates left.
module ledseq_multimode
   import ledseq_pkg::*;
#(
   parameter int N_LEDS   = 8,
   parameter int NB_COUNT = 32,
   parameter int NB_BASE  = 22
) (
   input  logic               clk,
   input  logic               i_reset,
   input  logic               i_enable,
   input  logic [1:0]         i_mode,
   input  logic [SPEED_W-1:0] i_speed,
   input  logic               i_color,
   output logic [N_LEDS-1:0]  o_led,
   output logic [N_LEDS-1:0]  o_led_b,
   output logic [N_LEDS-1:0]  o_led_g,
   output logic               o_tick,
   output logic               o_dir
);

   localparam logic [N_LEDS-1:0] ONEHOT_LSB = N_LEDS'(1);

   logic              advance;
   logic [N_LEDS-1:0] pattern;
   logic [N_LEDS-1:0] pattern_nxt;
   logic [N_LEDS-1:0] rot_left;
   logic [N_LEDS-1:0] rot_right;
   mode_e             mode;

   ledseq_prescaler #(
      .NB_COUNT (NB_COUNT),
      .NB_BASE  (NB_BASE)
   ) u_prescaler (
      .clk       (clk),
      .i_reset   (i_reset),
      .i_enable  (i_enable),
      .i_speed   (i_speed),
      .o_advance (advance),
      .o_tick    (o_tick)
   );

   assign mode      = mode_e'(i_mode);
   assign rot_left  = {pattern[N_LEDS-2:0], pattern[N_LEDS-1]};
   assign rot_right = {pattern[0], pattern[N_LEDS-1:1]};

`ifdef LEDSEQ_BOUNCE_EN
   logic dir_q;
   logic dir_nxt;

   // NOTE: every always_comb output gets a default first, so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      pattern_nxt = pattern;
      dir_nxt     = dir_q;
      if (mode == MODE_FLASH) begin
         pattern_nxt = ~pattern;
      end else if (!$onehot(pattern)) begin
         // Recovery from a flash-corrupted pattern also restarts the bounce upward.
         pattern_nxt = ONEHOT_LSB;
         dir_nxt     = 1'b0;
      end else begin
         case (mode)
            MODE_ROTR: pattern_nxt = rot_right;
            MODE_BOUNCE: begin
               if (!dir_q) begin
                  if (pattern[N_LEDS-1]) begin
                     dir_nxt     = 1'b1;
                     pattern_nxt = pattern >> 1;
                  end else begin
                     pattern_nxt = pattern << 1;
                  end
               end else begin
                  if (pattern[0]) begin
                     dir_nxt     = 1'b0;
                     pattern_nxt = pattern << 1;
                  end else begin
                     pattern_nxt = pattern >> 1;
                  end
               end
            end
            default: pattern_nxt = rot_left;
         endcase
      end
   end

   always_ff @(posedge clk or posedge i_reset) begin
      if (i_reset) begin
         dir_q <= 1'b0;
      end else if (advance) begin
         dir_q <= dir_nxt;
      end
   end

   assign o_dir = dir_q;
`else
   always_comb begin
      pattern_nxt = pattern;
      if (mode == MODE_FLASH) begin
         pattern_nxt = ~pattern;
      end else if (!$onehot(pattern)) begin
         pattern_nxt = ONEHOT_LSB;
      end else if (mode == MODE_ROTR) begin
         pattern_nxt = rot_right;
      end else begin
         pattern_nxt = rot_left;
      end
   end

   assign o_dir = 1'b0;
`endif

   always_ff @(posedge clk or posedge i_reset) begin
      if (i_reset) begin
         pattern <= ONEHOT_LSB;
      end else if (advance) begin
         pattern <= pattern_nxt;
      end
   end

   assign o_led   = pattern;
   assign o_led_b = i_color ? '0 : pattern;
   assign o_led_g = i_color ? pattern : '0;

endmodule

// File: tb/tb_ledseq_multimode.sv
// Self-checking bench for ledseq_multimode (N_LEDS=4, NB_BASE=2): directed table plus
// randomized run against a position-based reference model.
module tb_ledseq_multimode;

   logic       clk = 1'b0;
   logic       i_reset;
   logic       i_enable;
   logic [1:0] i_mode;
   logic [1:0] i_speed;
   logic       i_color;
   logic [3:0] o_led;
   logic [3:0] o_led_b;
   logic [3:0] o_led_g;
   logic       o_tick;
   logic       o_dir;

   int total = 0;
   int bad   = 0;

   // Reference model state
   int m_cnt;
   int m_pat;
   int m_dir;
   int m_tick;

   typedef struct {
      int mode;
      int speed;
      int color;
      int cyc;
      int led;
      int dir;
   } row_t;

   row_t rows[$];

   ledseq_multimode #(
      .N_LEDS   (4),
      .NB_COUNT (8),
      .NB_BASE  (2)
   ) dut (
      .clk      (clk),
      .i_reset  (i_reset),
      .i_enable (i_enable),
      .i_mode   (i_mode),
      .i_speed  (i_speed),
      .i_color  (i_color),
      .o_led    (o_led),
      .o_led_b  (o_led_b),
      .o_led_g  (o_led_g),
      .o_tick   (o_tick),
      .o_dir    (o_dir)
   );

   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_cnt  = 0;
      m_pat  = 1;
      m_dir  = 0;
      m_tick = 0;
   endtask

   // One rising edge of the reference model, from the rules on period and pattern.
   task automatic model_edge();
      int lim;
      int pos;
      int eff;
      lim    = (1 << (2 + int'(i_speed))) - 1;
      m_tick = 0;
      if (!i_enable) return;
      if (m_cnt < lim) begin
         m_cnt++;
         return;
      end
      m_cnt  = 0;
      m_tick = 1;
      if (i_mode == 2'd3) begin
         m_pat = ~m_pat & 4'hF;
      end else if ($countones(m_pat) != 1) begin
         m_pat = 1;
         m_dir = 0;
      end else begin
         pos = $clog2(m_pat);
         eff = int'(i_mode);
`ifndef LEDSEQ_BOUNCE_EN
         if (eff == 2) eff = 0;
`endif
         case (eff)
            0: pos = (pos + 1) % 4;
            1: pos = (pos + 3) % 4;
            default: begin
               if (m_dir == 0) begin
                  if (pos == 3) begin m_dir = 1; pos = 2; end
                  else pos = pos + 1;
               end else begin
                  if (pos == 0) begin m_dir = 0; pos = 1; end
                  else pos = pos - 1;
               end
            end
         endcase
         m_pat = 1 << pos;
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic wait_tick(output int n);
      n = 0;
      while (n < 64) begin
         step();
         n++;
         if (o_tick) break;
      end
   endtask

   // Called at posedge+1: asserts reset between edges and checks it acts at once.
   task automatic rst_pulse(input string tag);
      #2;
      i_reset = 1'b1;
      model_reset();
      #1;
      check({tag, "_led"}, int'(o_led), 1);
      check({tag, "_tick"}, int'(o_tick), 0);
      check({tag, "_dir"}, int'(o_dir), 0);
      #1;
      i_reset = 1'b0;
   endtask

   task automatic add(input int mode, input int speed, input int color,
                      input int cyc, input int led, input int dir);
      row_t r;
      r.mode = mode; r.speed = speed; r.color = color;
      r.cyc = cyc; r.led = led; r.dir = dir;
      rows.push_back(r);
   endtask

   initial begin
      int n;

      // Walk from reset: rotate-left, bounce (or its rotate-left stand-in), flash, recovery
      add(0, 0, 0, 4, 4'b0010, 0);
      add(0, 0, 1, 4, 4'b0100, 0);
      add(0, 0, 0, 4, 4'b1000, 0);
      add(0, 0, 1, 4, 4'b0001, 0);
`ifdef LEDSEQ_BOUNCE_EN
      add(2, 0, 0, 4, 4'b0010, 0);
      add(2, 0, 1, 4, 4'b0100, 0);
      add(2, 0, 0, 4, 4'b1000, 0);
      add(2, 0, 0, 4, 4'b0100, 1);
      add(2, 0, 1, 4, 4'b0010, 1);
      add(2, 0, 0, 4, 4'b0001, 1);
      add(2, 0, 1, 4, 4'b0010, 0);
      add(1, 1, 0, 8, 4'b0001, 0);
`else
      add(2, 0, 0, 4, 4'b0010, 0);
      add(2, 0, 1, 4, 4'b0100, 0);
      add(2, 0, 0, 4, 4'b1000, 0);
      add(2, 0, 1, 4, 4'b0001, 0);
      add(0, 1, 0, 8, 4'b0010, 0);
      add(1, 0, 1, 4, 4'b0001, 0);
`endif
      add(3, 0, 0, 4, 4'b1110, 0);
      add(3, 0, 1, 4, 4'b0001, 0);
      add(3, 0, 0, 4, 4'b1110, 0);
      add(1, 0, 1, 4, 4'b0001, 0);
      add(1, 0, 0, 4, 4'b1000, 0);
`ifdef LEDSEQ_BOUNCE_EN
      add(2, 0, 0, 4, 4'b0100, 1);
`else
      add(2, 0, 0, 4, 4'b0001, 0);
`endif

      i_reset  = 1'b1;
      i_enable = 1'b0;
      i_mode   = 2'd0;
      i_speed  = 2'd0;
      i_color  = 1'b0;
      #12;
      check("reset_led", int'(o_led), 1);
      check("reset_tick", int'(o_tick), 0);
      check("reset_dir", int'(o_dir), 0);
      check("reset_led_b", int'(o_led_b), 1);
      check("reset_led_g", int'(o_led_g), 0);
      #1;
      i_reset  = 1'b0;
      i_enable = 1'b1;

      foreach (rows[k]) begin
         i_mode  = 2'(rows[k].mode);
         i_speed = 2'(rows[k].speed);
         i_color = rows[k].color[0];
         wait_tick(n);
         check($sformatf("row%0d_cycles", k), n, rows[k].cyc);
         check($sformatf("row%0d_led", k), int'(o_led), rows[k].led);
         check($sformatf("row%0d_dir", k), int'(o_dir), rows[k].dir);
         check($sformatf("row%0d_led_b", k), int'(o_led_b), rows[k].color ? 0 : rows[k].led);
         check($sformatf("row%0d_led_g", k), int'(o_led_g), rows[k].color ? rows[k].led : 0);
      end

      // Reset between edges while travelling down, then color swap during reset
      #2;
      i_reset = 1'b1;
      #1;
      check("midrst_led", int'(o_led), 1);
      check("midrst_dir", int'(o_dir), 0);
      check("midrst_tick", int'(o_tick), 0);
      i_color = 1'b0;
      #1;
      check("midrst_b_c0", int'(o_led_b), 1);
      check("midrst_g_c0", int'(o_led_g), 0);
      i_color = 1'b1;
      #1;
      check("midrst_b_c1", int'(o_led_b), 0);
      check("midrst_g_c1", int'(o_led_g), 1);
      i_reset = 1'b0;
      i_color = 1'b0;

      // Speed drop below the running count ticks on the next edge
      i_mode  = 2'd0;
      i_speed = 2'd3;
      n = 0;
      repeat (20) begin
         step();
         if (o_tick) n++;
      end
      check("slow_no_tick", n, 0);
      i_speed = 2'd0;
      step();
      check("speed_drop_tick", int'(o_tick), 1);
      check("speed_drop_led", int'(o_led), 4'b0010);
      wait_tick(n);
      check("speed_drop_period", n, 4);
      check("speed_drop_led2", int'(o_led), 4'b0100);

      // Freeze mid-count and resume from the held count
      step();
      step();
      i_enable = 1'b0;
      for (int j = 0; j < 10; j++) begin
         step();
         check($sformatf("freeze%0d_tick", j), int'(o_tick), 0);
         check($sformatf("freeze%0d_led", j), int'(o_led), 4'b0100);
         check($sformatf("freeze%0d_dir", j), int'(o_dir), 0);
      end
      i_enable = 1'b1;
      wait_tick(n);
      check("resume_cycles", n, 2);
      check("resume_led", int'(o_led), 4'b1000);

      // Randomized run against the reference model
      rst_pulse("rand_start");
      for (int c = 0; c < 3000; c++) begin
         i_enable = ($urandom_range(0, 9) != 0);
         if ($urandom_range(0, 19) == 0) i_mode = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 59) == 0) i_speed = 2'($urandom_range(0, 3));
         i_color = 1'($urandom_range(0, 1));
         step();
         check($sformatf("rand%0d_led", c), int'(o_led), m_pat);
         check($sformatf("rand%0d_tick", c), int'(o_tick), m_tick);
         check($sformatf("rand%0d_dir", c), int'(o_dir), m_dir);
         check($sformatf("rand%0d_led_b", c), int'(o_led_b), i_color ? 0 : m_pat);
         check($sformatf("rand%0d_led_g", c), int'(o_led_g), i_color ? m_pat : 0);
         if ($urandom_range(0, 399) == 0) rst_pulse($sformatf("rand%0d_rst", c));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ledseq_multimode.md
LEDSEQ_MULTIMODE -- requirements
Module: ledseq_multimode

Interface
- REQ-001 Parameter N_LEDS, default 8: LED count; legal values ≥ 2.
- REQ-002 Parameter NB_COUNT, default 32: prescaler counter width.
- REQ-003 Parameter NB_BASE, default 22: log2 of the base period; NB_BASE+4 ≤ NB_COUNT.
- REQ-004 clk  in  1  single clock; all logic is on the rising edge.
- REQ-005 i_reset  in  1  asynchronous, active-high reset.
- REQ-006 i_enable  in  1  run (1) or freeze (0).
- REQ-007 i_mode  in  2  pattern mode: 0 rotate-left, 1 rotate-right, 2 bounce, 3 flash.
- REQ-008 i_speed  in  2  period select.
- REQ-009 i_color  in  1  routes the pattern to o_led_b (0) or o_led_g (1).
- REQ-010 o_led  out  N_LEDS  current pattern.
- REQ-011 o_led_b / o_led_g  out  N_LEDS each  pattern when selected by i_color, else all zeros; combinational from the pattern register and i_color.
- REQ-012 o_tick  out  1  registered one-cycle pulse, asserted in the cycle the pattern updates.
- REQ-013 o_dir  out  1  bounce direction: 0 up (toward MSB), 1 down.

Function
- REQ-014 Limit: limit = 2^(NB_BASE+i_speed) - 1, evaluated combinationally every cycle.
- REQ-015 Enable low: counter, pattern and o_dir hold; o_tick = 0.
- REQ-016 Enable high, counter < limit: counter increments by 1; o_tick = 0.
- REQ-017 Enable high, counter ≥ limit: counter clears, o_tick = 1 and the pattern updates, all on the same edge. Period is therefore limit+1 cycles.
- REQ-018 Speed change mid-count: the ≥ compare applies; if the new limit is below the current count, the tick occurs on the next enabled edge.
- REQ-019 Mode 0: the pattern rotates left by one (MSB wraps to LSB).
- REQ-020 Mode 1: the pattern rotates right by one (LSB wraps to MSB).
- REQ-021 Mode 2, up: shift left. If pattern[N_LEDS-1] = 1, o_dir becomes 1 and the pattern shifts right instead (no dwell at the end).
- REQ-022 Mode 2, down: mirror of REQ-021 at bit 0; o_dir becomes 0.
- REQ-023 Mode 3: the pattern is bitwise inverted each tick.
- REQ-024 In modes 0–2, a tick with a non-one-hot pattern (zero or more than one bit set) loads the one-hot LSB pattern (1 in bit 0) instead of shifting, and clears o_dir.
- REQ-025 Mode is sampled only at tick; mode changes between ticks do not affect the counter or the pattern.
- REQ-026 o_dir changes only in mode 2; in other modes it holds its value.

Reset
- REQ-027 Reset values: counter = 0, pattern = one-hot LSB, o_dir = 0, o_tick = 0. o_led_b = pattern when i_color = 0; o_led_g = pattern when i_color = 1.
- REQ-028 Reset asserted mid-operation takes effect immediately, regardless of clk and i_enable.
- REQ-029 The first tick after reset release occurs limit+1 enabled cycles later.

Configuration
- REQ-030 Macro LEDSEQ_BOUNCE_EN. Defined: mode 2 behaves per REQ-021/022. Undefined: mode 2 behaves as mode 0, the direction register is removed, and o_dir is tied to 0.

Structure
- REQ-031 Shared package ledseq_pkg holds the mode encodings (MODE_ROTL, MODE_ROTR, MODE_BOUNCE, MODE_FLASH) and the speed select width, 2.
- REQ-032 Sub-module ledseq_prescaler contains the counter, the limit compare and o_tick generation. It takes enable and speed as inputs and outputs the tick.

Verification (N_LEDS=4, NB_BASE=2; limits 3/7/15/31)
- REQ-033 Reset; mode 0, speed 0, enable 1 -> o_tick every 4 cycles; o_led = 0001, 0010, 0100, 1000, 0001.
- REQ-034 Mode 2 from 0001 -> 0010, 0100, 1000, 0100, 0010, 0001, 0010; o_dir = 1 after the 1000 step, 0 after the 0001 step.
- REQ-035 Mode 3 for two ticks (0001 -> 1110 -> 0001), then one more tick (-> 1110), switch to mode 1 -> the next tick gives 0001 per REQ-024, the following tick 1000.
- REQ-036 Speed 3 with counter at 20, switch to speed 0 -> o_tick on the next edge; subsequent period 4 cycles.
- REQ-037 Enable low for 10 cycles mid-count -> o_led, counter and o_dir frozen, o_tick = 0; count resumes from the held value.
- REQ-038 Assert i_reset between clock edges during mode 2 down-travel -> o_led = 0001 and o_dir = 0 immediately; i_color toggle swaps o_led_b/o_led_g combinationally.
